// File: rtl/simplerisc_pkg.sv
// Shared register-file parameters and writeback payload, used by the register file,
// the writeback controller and the hazard unit.
package simplerisc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREG   = 1 << ADDR_W;
  localparam int unsigned RA_IDX = 15;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NREG-1:0] reg_onehot(input logic [ADDR_W-1:0] idx);
    return NREG'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry writeback FIFO; exposes every slot's valid/rd so the owner can build
// a pending-write mask.
module wb_fifo
  import simplerisc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  wb_entry_t                  din,
  input  logic                       pop,
  output wb_entry_t                  head_c,
  output logic [1:0]                 count,
  output logic [1:0]                 ent_vld_c,
  output logic [1:0][ADDR_W-1:0]     ent_rd_c
);

  logic [1:0] cnt_q;
  logic       rptr_q;
  logic       wptr_q;
  wb_entry_t  mem_q [2];
  logic       do_push;
  logic       do_pop;

  // Guards make the FIFO safe even if the owner pushes when full or pops when empty.
  assign do_push = push && (cnt_q != 2'd2);
  assign do_pop  = pop  && (cnt_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign count  = cnt_q;
  assign head_c = mem_q[rptr_q];

  always_comb begin
    ent_vld_c = '0;
    ent_rd_c  = '0;
    for (int i = 0; i < 2; i++) begin
      ent_rd_c[i]  = mem_q[i].rd;
      ent_vld_c[i] = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && (rptr_q == 1'(i)));
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: buffers ALU and load results, arbitrates one register-file
// write per cycle with load priority and bounded ALU starvation.
module regfile_wb_ctrl
  import simplerisc_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic              alu_isCall,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              isWb,
  output logic [ADDR_W-1:0] rd_ra,
  output logic [DATA_W-1:0] data,
  output logic [NREG-1:0]   pend_mask,
  output logic              busy
);

  wb_entry_t             alu_in, ld_in, alu_head_c, ld_head_c;
  logic [1:0]            alu_cnt, ld_cnt;
  logic [1:0]            alu_ev, ld_ev;
  logic [1:0][ADDR_W-1:0] alu_er, ld_er;
  logic                  alu_ne, ld_ne;
  logic                  grant_alu_c, grant_ld_c;
  logic [1:0]            starve_q;

  always_comb begin
    alu_in.rd   = alu_isCall ? ADDR_W'(RA_IDX) : alu_rd;
    alu_in.data = alu_data;
    ld_in.rd    = ld_rd;
    ld_in.data  = ld_data;
  end

  // Ready looks only at the registered count, so a full FIFO popping this cycle stays not-ready.
  assign alu_ready = (alu_cnt != 2'd2);
  assign ld_ready  = (ld_cnt != 2'd2);
  assign alu_ne    = (alu_cnt != 2'd0);
  assign ld_ne     = (ld_cnt != 2'd0);

  wb_fifo u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_valid && alu_ready),
    .din       (alu_in),
    .pop       (grant_alu_c),
    .head_c    (alu_head_c),
    .count     (alu_cnt),
    .ent_vld_c (alu_ev),
    .ent_rd_c  (alu_er)
  );

  wb_fifo u_ld_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ld_valid && ld_ready),
    .din       (ld_in),
    .pop       (grant_ld_c),
    .head_c    (ld_head_c),
    .count     (ld_cnt),
    .ent_vld_c (ld_ev),
    .ent_rd_c  (ld_er)
  );

  // Load wins unless the ALU has waited through STARVE_MAX load grants.
  always_comb begin
    grant_alu_c = 1'b0;
    grant_ld_c  = 1'b0;
    if (alu_ne && (!ld_ne || (starve_q == 2'(STARVE_MAX)))) grant_alu_c = 1'b1;
    else if (ld_ne) grant_ld_c = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 2'd0;
      isWb     <= 1'b0;
      rd_ra    <= '0;
      data     <= '0;
    end else begin
      if (!alu_ne || grant_alu_c) starve_q <= 2'd0;
      else if (grant_ld_c)        starve_q <= starve_q + 2'd1;
      isWb <= grant_alu_c | grant_ld_c;
      if (grant_alu_c) begin
        rd_ra <= alu_head_c.rd;
        data  <= alu_head_c.data;
      end else if (grant_ld_c) begin
        rd_ra <= ld_head_c.rd;
        data  <= ld_head_c.data;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < 2; i++) begin
      if (alu_ev[i]) pend_mask = pend_mask | reg_onehot(alu_er[i]);
      if (ld_ev[i])  pend_mask = pend_mask | reg_onehot(ld_er[i]);
    end
    if (isWb) pend_mask = pend_mask | reg_onehot(rd_ra);
  end

  assign busy = |pend_mask;

endmodule
